acc_breg_alu: RTL and testbench

- SAP-1 style arithmetic datapath slice: an accumulator register (A), a B register, and a registered add/subtract unit that computes A±B.
- Sits between the shared 8-bit system bus and the controller/sequencer.
- Registers load from the bus or from the front-panel programming input.
- Any of the three sources can drive a shared bus output.

---
 rtl/acc_breg_alu.sv | 116 +++++++++++
 tb/tb_acc_breg_alu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_breg_alu.sv
// SAP-1 style datapath slice: accumulator A, B register, registered add/subtract unit and bus driver.
// Optional feature: define ACC_SAT_EN for unsigned saturating ALU results (default build wraps modulo 2^WIDTH).
module acc_breg_alu #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] bus_in,
   input  logic [WIDTH-1:0] prog_in,
   input  logic             WE_Acc,
   input  logic             load_Acc,
   input  logic             OE_Acc,
   input  logic             WE_Breg,
   input  logic             load_Breg,
   input  logic             OE_Breg,
   input  logic             OE_ALU,
   input  logic             SUB,
   output logic [WIDTH-1:0] Acc_out,
   output logic [WIDTH-1:0] Breg_out,
   output logic [WIDTH-1:0] ALU_out,
   output logic             carry,
   output logic             zero,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_valid
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] breg_q;
   logic [WIDTH-1:0] alu_q;
   logic             carry_q;
   logic             zero_q;

   logic [WIDTH:0]   alu_full;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] breg_next;

   // Subtraction is A + ~B + 1, so the top bit doubles as the no-borrow flag.
   always_comb begin
      alu_full = '0;
      if (SUB) begin
         alu_full = {1'b0, acc_q} + {1'b0, ~breg_q} + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         alu_full = {1'b0, acc_q} + {1'b0, breg_q};
      end
   end

`ifdef ACC_SAT_EN
   always_comb begin
      alu_result = alu_full[WIDTH-1:0];
      if (!SUB && alu_full[WIDTH]) begin
         alu_result = {WIDTH{1'b1}};
      end else if (SUB && !alu_full[WIDTH]) begin
         alu_result = '0;
      end
   end
`else
   always_comb begin
      alu_result = alu_full[WIDTH-1:0];
   end
`endif

   // Bus loads take priority over front-panel loads.
   always_comb begin
      acc_next = acc_q;
      if (WE_Acc) begin
         acc_next = bus_in;
      end else if (load_Acc) begin
         acc_next = prog_in;
      end
   end

   always_comb begin
      breg_next = breg_q;
      if (WE_Breg) begin
         breg_next = bus_in;
      end else if (load_Breg) begin
         breg_next = prog_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         acc_q   <= '0;
         breg_q  <= '0;
         alu_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         acc_q   <= acc_next;
         breg_q  <= breg_next;
         alu_q   <= alu_result;
         carry_q <= alu_full[WIDTH];
         zero_q  <= (alu_result == '0);
      end
   end

   always_comb begin
      bus_out = '0;
      if (OE_Acc) begin
         bus_out = acc_q;
      end else if (OE_Breg) begin
         bus_out = breg_q;
      end else if (OE_ALU) begin
         bus_out = alu_q;
      end
   end

   assign bus_valid = OE_Acc | OE_Breg | OE_ALU;
   assign Acc_out   = acc_q;
   assign Breg_out  = breg_q;
   assign ALU_out   = alu_q;
   assign carry     = carry_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_acc_breg_alu.sv
// Self-checking bench for acc_breg_alu: directed scenarios plus randomized traffic against an arithmetic model.
// Honours ACC_SAT_EN the same way the design does.
module tb_acc_breg_alu;

   localparam int WIDTH = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             CLK;
   logic             RESET;
   logic [WIDTH-1:0] bus_in, prog_in;
   logic             WE_Acc, load_Acc, OE_Acc;
   logic             WE_Breg, load_Breg, OE_Breg;
   logic             OE_ALU, SUB;
   logic [WIDTH-1:0] Acc_out, Breg_out, ALU_out, bus_out;
   logic             carry, zero, bus_valid;

   int checks   = 0;
   int failures = 0;

   int m_a, m_b, m_alu;
   bit m_carry, m_zero;

   acc_breg_alu #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .RESET(RESET), .bus_in(bus_in), .prog_in(prog_in),
      .WE_Acc(WE_Acc), .load_Acc(load_Acc), .OE_Acc(OE_Acc),
      .WE_Breg(WE_Breg), .load_Breg(load_Breg), .OE_Breg(OE_Breg),
      .OE_ALU(OE_ALU), .SUB(SUB),
      .Acc_out(Acc_out), .Breg_out(Breg_out), .ALU_out(ALU_out),
      .carry(carry), .zero(zero), .bus_out(bus_out), .bus_valid(bus_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic applyStimulus(input bit we_a, input bit ld_a, input bit we_b, input bit ld_b,
                                input bit sub, input int bus_v, input int prog_v);
      WE_Acc = we_a; load_Acc = ld_a; WE_Breg = we_b; load_Breg = ld_b;
      SUB = sub; bus_in = bus_v[WIDTH-1:0]; prog_in = prog_v[WIDTH-1:0];
   endtask

   // Model: A +/- B done in plain integers, then reduced or clamped to WIDTH bits.
   task automatic tick();
      int na, nb, full, res;
      bit nc;
      if (!RESET) begin
         na = 0; nb = 0; res = 0; nc = 0;
      end else begin
         na = WE_Acc ? int'(bus_in) : (load_Acc ? int'(prog_in) : m_a);
         nb = WE_Breg ? int'(bus_in) : (load_Breg ? int'(prog_in) : m_b);
         if (SUB) begin
            full = m_a - m_b;
            nc   = (m_a >= m_b);
            res  = (full + MAXV + 1) % (MAXV + 1);
`ifdef ACC_SAT_EN
            if (!nc) res = 0;
`endif
         end else begin
            full = m_a + m_b;
            nc   = (full > MAXV);
            res  = full % (MAXV + 1);
`ifdef ACC_SAT_EN
            if (nc) res = MAXV;
`endif
         end
      end
      @(posedge CLK);
      #1;
      m_a = na; m_b = nb; m_alu = res; m_carry = nc; m_zero = (res == 0);
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      OE_Acc = 0; OE_Breg = 0; OE_ALU = 0;
      applyStimulus(1, 1, 1, 1, 1, 8'h9C, 8'h37);
      tick();
      tick();
      checks++; if (Acc_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_acc got=%h exp=00", Acc_out); end
      checks++; if (Breg_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_breg got=%h exp=00", Breg_out); end
      checks++; if (ALU_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_alu got=%h exp=00", ALU_out); end
      checks++; if (carry !== 1'b0) begin failures++; $display("[TB] FAIL reset_carry got=%b exp=0", carry); end
      checks++; if (zero !== 1'b1) begin failures++; $display("[TB] FAIL reset_zero got=%b exp=1", zero); end
      RESET = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_load_path();
      applyStimulus(0, 1, 1, 0, 0, 8'h05, 8'h12);
      tick();
      checks++; if (Acc_out !== 8'h12) begin failures++; $display("[TB] FAIL load_acc got=%h exp=12", Acc_out); end
      checks++; if (Breg_out !== 8'h05) begin failures++; $display("[TB] FAIL load_breg got=%h exp=05", Breg_out); end
      applyStimulus(0, 0, 0, 0, 0, 8'hEE, 8'hDD);
      tick();
      checks++; if ({ALU_out, carry, zero} !== {8'h17, 1'b0, 1'b0})
         begin failures++; $display("[TB] FAIL add_12_05 got=%h c=%b z=%b exp=17 c=0 z=0", ALU_out, carry, zero); end
      SUB = 1'b1;
      tick();
      checks++; if ({ALU_out, carry, zero} !== {8'h0D, 1'b1, 1'b0})
         begin failures++; $display("[TB] FAIL sub_12_05 got=%h c=%b z=%b exp=0d c=1 z=0", ALU_out, carry, zero); end
   endtask

   task automatic test_priority();
      applyStimulus(1, 1, 1, 1, 0, 8'hAA, 8'h55);
      tick();
      checks++; if (Acc_out !== 8'hAA) begin failures++; $display("[TB] FAIL prio_acc got=%h exp=aa", Acc_out); end
      checks++; if (Breg_out !== 8'hAA) begin failures++; $display("[TB] FAIL prio_breg got=%h exp=aa", Breg_out); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_alu;
      logic       exp_zero;
`ifdef ACC_SAT_EN
      exp_alu = 8'hFF; exp_zero = 1'b0;
`else
      exp_alu = 8'h00; exp_zero = 1'b1;
`endif
      applyStimulus(0, 1, 1, 0, 0, 8'h01, 8'hFF);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++; if ({ALU_out, carry, zero} !== {exp_alu, 1'b1, exp_zero})
         begin failures++; $display("[TB] FAIL overflow got=%h c=%b z=%b exp=%h c=1 z=%b", ALU_out, carry, zero, exp_alu, exp_zero); end
   endtask

   task automatic test_underflow();
      logic [7:0] exp_alu;
      logic       exp_zero;
`ifdef ACC_SAT_EN
      exp_alu = 8'h00; exp_zero = 1'b1;
`else
      exp_alu = 8'hFE; exp_zero = 1'b0;
`endif
      applyStimulus(1, 0, 0, 1, 1, 8'h03, 8'h05);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      tick();
      checks++; if ({ALU_out, carry, zero} !== {exp_alu, 1'b0, exp_zero})
         begin failures++; $display("[TB] FAIL underflow got=%h c=%b z=%b exp=%h c=0 z=%b", ALU_out, carry, zero, exp_alu, exp_zero); end
   endtask

   task automatic test_bus_mux();
      applyStimulus(0, 1, 1, 0, 0, 8'h22, 8'h11);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      OE_Acc = 0; OE_Breg = 1; OE_ALU = 1;
      #1;
      checks++; if ({bus_out, bus_valid} !== {8'h22, 1'b1})
         begin failures++; $display("[TB] FAIL bus_breg_over_alu got=%h v=%b exp=22 v=1", bus_out, bus_valid); end
      OE_Acc = 1;
      #1;
      checks++; if ({bus_out, bus_valid} !== {8'h11, 1'b1})
         begin failures++; $display("[TB] FAIL bus_acc_first got=%h v=%b exp=11 v=1", bus_out, bus_valid); end
      OE_Acc = 0; OE_Breg = 0;
      #1;
      checks++; if ({bus_out, bus_valid} !== {8'h33, 1'b1})
         begin failures++; $display("[TB] FAIL bus_alu got=%h v=%b exp=33 v=1", bus_out, bus_valid); end
      OE_ALU = 0;
      #1;
      checks++; if ({bus_out, bus_valid} !== {8'h00, 1'b0})
         begin failures++; $display("[TB] FAIL bus_idle got=%h v=%b exp=00 v=0", bus_out, bus_valid); end
   endtask

   task automatic test_oe_we_same();
      OE_Acc = 1;
      applyStimulus(1, 0, 0, 0, 0, 8'h6B, 0);
      #1;
      checks++; if (bus_out !== 8'h11) begin failures++; $display("[TB] FAIL oe_we_old got=%h exp=11", bus_out); end
      tick();
      checks++; if (Acc_out !== 8'h6B) begin failures++; $display("[TB] FAIL oe_we_new got=%h exp=6b", Acc_out); end
      OE_Acc = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Random traffic; bus checked combinationally before each edge, registers after it.
   task automatic test_random();
      int exp_bus;
      for (int i = 0; i < 400; i++) begin
         RESET = ($urandom_range(0, 31) != 0);
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
         if (i % 4 == 0) bus_in = (i % 8 == 0) ? 8'hFF : 8'h00;
         OE_Acc = $urandom_range(0, 2) == 0; OE_Breg = $urandom_range(0, 2) == 0; OE_ALU = $urandom_range(0, 2) == 0;
         #1;
         exp_bus = OE_Acc ? m_a : (OE_Breg ? m_b : (OE_ALU ? m_alu : 0));
         checks++; if ({bus_out, bus_valid} !== {exp_bus[WIDTH-1:0], OE_Acc | OE_Breg | OE_ALU})
            begin failures++; $display("[TB] FAIL rand_bus i=%0d got=%h v=%b exp=%h", i, bus_out, bus_valid, exp_bus[WIDTH-1:0]); end
         tick();
         checks++; if ({Acc_out, Breg_out} !== {m_a[WIDTH-1:0], m_b[WIDTH-1:0]})
            begin failures++; $display("[TB] FAIL rand_regs i=%0d got=%h/%h exp=%h/%h", i, Acc_out, Breg_out, m_a[WIDTH-1:0], m_b[WIDTH-1:0]); end
         checks++; if ({ALU_out, carry, zero} !== {m_alu[WIDTH-1:0], m_carry, m_zero})
            begin failures++; $display("[TB] FAIL rand_alu i=%0d got=%h c=%b z=%b exp=%h c=%b z=%b", i, ALU_out, carry, zero, m_alu[WIDTH-1:0], m_carry, m_zero); end
      end
      RESET = 1'b1;
      OE_Acc = 0; OE_Breg = 0; OE_ALU = 0;
   endtask

   initial begin
      m_a = 0; m_b = 0; m_alu = 0; m_carry = 0; m_zero = 1;
      test_reset();
      test_load_path();
      test_priority();
      test_overflow();
      test_underflow();
      test_bus_mux();
      test_oe_we_same();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
